// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 multiplier: start/busy/done handshake, one-bit-per-cycle shift-add
// significand product, round-to-nearest-even, denormals flushed to zero.
module fp_mul_seq #(
    parameter int PRECISION = 32,
    parameter int EXPONENT  = 8,
    parameter int FRACTION  = 23,
    parameter int BIAS      = 127
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [PRECISION-1:0] a_operand,
    input  logic [PRECISION-1:0] b_operand,
    output logic                 busy,
    output logic                 done,
    output logic [PRECISION-1:0] result
);
    localparam int SIG = FRACTION + 1;
    localparam int PW  = 2 * SIG;
    localparam int CW  = $clog2(SIG + 1);
    localparam int EW  = EXPONENT + 2;
    localparam logic [EXPONENT-1:0]  EXP_ONES = '1;
    localparam logic signed [EW-1:0] E_INF    = EW'((1 << EXPONENT) - 1);
    localparam logic signed [EW-1:0] E_ZERO   = '0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_PACK} state_t;
    state_t r_state, w_next;

    logic                   r_sign;
    logic [EXPONENT-1:0]    r_a_exp, r_b_exp;
    logic                   r_a_fnz, r_b_fnz;
    logic [PW-1:0]          r_mcand, r_acc;
    logic [SIG-1:0]         r_mplier;
    logic [CW-1:0]          r_cnt;
    logic [FRACTION-1:0]    r_mant;
    logic signed [EW-1:0]   r_exp;
    logic                   r_done;
    logic [PRECISION-1:0]   r_result;

    logic                   w_top, w_guard, w_sticky, w_inc;
    logic [FRACTION-1:0]    w_mant_pre;
    logic [FRACTION:0]      w_mant_rnd;
    logic [EW-1:0]          w_exp_norm;
    logic                   w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [PRECISION-1:0]   w_pack;

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign result = r_result;

    // Normalize: the product of two [1,2) significands lies in [1,4), so at most one extra shift.
    assign w_top      = r_acc[PW-1];
    assign w_mant_pre = w_top ? r_acc[PW-2 -: FRACTION] : r_acc[PW-3 -: FRACTION];
    assign w_guard    = w_top ? r_acc[PW-2-FRACTION] : r_acc[PW-3-FRACTION];
    assign w_sticky   = w_top ? (|r_acc[PW-3-FRACTION:0]) : (|r_acc[PW-4-FRACTION:0]);
    assign w_inc      = w_guard & (w_sticky | w_mant_pre[0]);
    assign w_mant_rnd = {1'b0, w_mant_pre} + (FRACTION+1)'(w_inc);
    assign w_exp_norm = EW'(r_a_exp) + EW'(r_b_exp) - EW'(BIAS) + EW'(w_top);

    assign w_a_nan  = (r_a_exp == EXP_ONES) &  r_a_fnz;
    assign w_b_nan  = (r_b_exp == EXP_ONES) &  r_b_fnz;
    assign w_a_inf  = (r_a_exp == EXP_ONES) & ~r_a_fnz;
    assign w_b_inf  = (r_b_exp == EXP_ONES) & ~r_b_fnz;
    assign w_a_zero = (r_a_exp == '0);
    assign w_b_zero = (r_b_exp == '0);

    always_comb begin
        w_pack = {r_sign, r_exp[EXPONENT-1:0], r_mant};
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero))
            w_pack = {1'b0, EXP_ONES, 1'b1, {(FRACTION-1){1'b0}}};
        else if (w_a_inf | w_b_inf)
            w_pack = {r_sign, EXP_ONES, {FRACTION{1'b0}}};
        else if (w_a_zero | w_b_zero)
            w_pack = {r_sign, {(PRECISION-1){1'b0}}};
        else if (r_exp >= E_INF)
            w_pack = {r_sign, EXP_ONES, {FRACTION{1'b0}}};
        else if (r_exp <= E_ZERO)
            w_pack = {r_sign, {(PRECISION-1){1'b0}}};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_MUL;
            S_MUL:  if (r_cnt == CW'(1)) w_next = S_NORM;
            S_NORM: w_next = S_PACK;
            S_PACK: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sign   <= 1'b0;
            r_a_exp  <= '0;
            r_b_exp  <= '0;
            r_a_fnz  <= 1'b0;
            r_b_fnz  <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_mant   <= '0;
            r_exp    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_sign   <= a_operand[PRECISION-1] ^ b_operand[PRECISION-1];
                    r_a_exp  <= a_operand[PRECISION-2 -: EXPONENT];
                    r_b_exp  <= b_operand[PRECISION-2 -: EXPONENT];
                    r_a_fnz  <= |a_operand[FRACTION-1:0];
                    r_b_fnz  <= |b_operand[FRACTION-1:0];
                    r_mcand  <= PW'({1'b1, a_operand[FRACTION-1:0]});
                    r_mplier <= {1'b1, b_operand[FRACTION-1:0]};
                    r_acc    <= '0;
                    r_cnt    <= CW'(SIG);
                end
                S_MUL: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                end
                // Rounding carry-out leaves the fraction field at zero and bumps the exponent.
                S_NORM: begin
                    r_mant <= w_mant_rnd[FRACTION-1:0];
                    r_exp  <= w_exp_norm + EW'(w_mant_rnd[FRACTION]);
                end
                S_PACK: begin
                    r_result <= w_pack;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: arithmetic reference model, per-cycle output compare, directed and random ops.
module tb_fp_mul_seq;
    localparam int LAT = 26;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [31:0] a_operand = '0, b_operand = '0;
    logic        busy, done;
    logic [31:0] result;

    fp_mul_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .a_operand(a_operand), .b_operand(b_operand),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference product from real-number reasoning: exact integer product, remainder-based rounding.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic s;
        longint unsigned p, m, rem, half;
        int sh, e;
        bit nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
        s = a[31] ^ b[31];
        nan_a = (ea == 8'hFF) && (fa != 0); nan_b = (eb == 8'hFF) && (fb != 0);
        inf_a = (ea == 8'hFF) && (fa == 0); inf_b = (eb == 8'hFF) && (fb == 0);
        z_a = (ea == 0); z_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) return 32'h7FC00000;
        if (inf_a || inf_b) return {s, 8'hFF, 23'h0};
        if (z_a || z_b) return {s, 31'h0};
        p = (longint'(1) << 23 | longint'(fa)) * (longint'(1) << 23 | longint'(fb));
        sh = (p >= (longint'(1) << 47)) ? 24 : 23;
        m = p >> sh;
        rem = p - (m << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && m[0])) m = m + 1;
        e = int'(ea) + int'(eb) - 127 + (sh - 23);
        if (m == (longint'(1) << 24)) begin m = m >> 1; e = e + 1; end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        logic [22:0] f;
        int sel;
        sel = $urandom_range(0, 9);
        f = 23'($urandom);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = '0; end
        else if (sel < 6) e = 8'($urandom_range(100, 154));
        else e = 8'($urandom);
        if ($urandom_range(0, 4) == 0) f = 23'($urandom_range(0, 3));
        return {1'($urandom), e, f};
    endfunction

    // Cycle model of the handshake: accept in idle, done LAT edges later, result held.
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_result = '0, m_pend = '0;
    longint      m_cyc = 0, m_end = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_result <= '0;
        end else begin
            m_cyc  <= m_cyc + 1;
            m_done <= m_busy && (m_cyc + 1 == m_end);
            if (m_busy && (m_cyc + 1 == m_end)) begin
                m_busy   <= 1'b0;
                m_result <= m_pend;
            end else if (!m_busy && start) begin
                m_busy <= 1'b1;
                m_end  <= m_cyc + 1 + LAT;
                m_pend <= fp_model(a_operand, b_operand);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("cyc busy",   {31'b0, busy}, {31'b0, m_busy});
            chk("cyc done",   {31'b0, done}, {31'b0, m_done});
            chk("cyc result", result, m_result);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj,
                          output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        a_operand = a; b_operand = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_operand = $urandom; b_operand = $urandom;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            start = (lat == inj);
        end
        start = 1'b0;
        res = result;
    endtask

    task automatic vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int inj);
        logic [31:0] r;
        int lat, bc;
        chk({nm, " model"}, fp_model(a, b), exp);
        run_op(a, b, inj, r, lat, bc);
        chk({nm, " result"}, r, exp);
        chk({nm, " latency"}, 32'(lat), 32'(LAT));
        chk({nm, " busy cycles"}, 32'(bc), 32'(LAT));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [31:0] r, a, b, expv;
        int lat, bc, t;

        @(negedge clk);
        chk("reset busy",   {31'b0, busy}, 32'd0);
        chk("reset done",   {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        vec("2x3",          32'h40000000, 32'h40400000, 32'h40C00000, -1);
        vec("1.5x1.5",      32'h3FC00000, 32'h3FC00000, 32'h40100000, -1);
        vec("-2x0.5",       32'hC0000000, 32'h3F000000, 32'hBF800000, -1);
        vec("round down",   32'h3F800001, 32'h3F800001, 32'h3F800002, -1);
        vec("tie even",     32'h3F800001, 32'h3FC00000, 32'h3FC00002, -1);
        vec("overflow",     32'h7F000000, 32'h7F000000, 32'h7F800000, -1);
        vec("zero x max",   32'h00000000, 32'h7F7FFFFF, 32'h00000000, -1);
        vec("inf x zero",   32'h7F800000, 32'h00000000, 32'h7FC00000, -1);
        vec("underflow",    32'h00800000, 32'h00800000, 32'h00000000, -1);
        vec("mid-MUL start",32'h40000000, 32'h40400000, 32'h40C00000, 5);

        // start held through done: the second op is captured on the edge after the done cycle
        @(negedge clk);
        a_operand = 32'h40000000; b_operand = 32'h40400000; start = 1'b1;
        t = 0;
        while (!done && t < 100) begin @(negedge clk); t++; end
        chk("held first latency", 32'(t), 32'(LAT + 1));
        chk("held first result", result, 32'h40C00000);
        a_operand = 32'h3FC00000; b_operand = 32'h3FC00000;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!done && t < 100) begin @(negedge clk); t++; end
        chk("held done gap", 32'(t + 1), 32'(LAT + 1));
        chk("held second result", result, 32'h40100000);

        // abort in the middle of the multiply loop
        @(negedge clk);
        a_operand = 32'h40000000; b_operand = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort busy",   {31'b0, busy}, 32'd0);
        chk("abort done",   {31'b0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        vec("after abort", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, -1);

        for (int i = 0; i < 150; i++) begin
            a = rand_fp();
            b = rand_fp();
            expv = fp_model(a, b);
            run_op(a, b, -1, r, lat, bc);
            chk("rand result", r, expv);
            chk("rand latency", 32'(lat), 32'(LAT));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
